// File: rtl/fetch_predictor.sv
// IF-stage PC generator with a direct-mapped BTB and 2-bit direction counters.
// Optional statistics counters are built only when BHT_STATS_EN is defined.
module fetch_predictor #(
    parameter int                ADDR_W   = 10,
    parameter int                IDX_W    = 3,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_4,
    output logic [ADDR_W-1:0] pc_guessed,
    output logic [1:0]        bht_state,
    output logic [31:0]       stat_lookups,
    output logic [31:0]       stat_mispred
);

    localparam int ENTRIES = 1 << IDX_W;
    localparam int TAG_W   = ADDR_W - IDX_W;

    logic [ENTRIES-1:0] tbl_valid;
    logic [TAG_W-1:0]   tbl_tag    [ENTRIES];
    logic [ADDR_W-1:0]  tbl_target [ENTRIES];
    logic [1:0]         tbl_cnt    [ENTRIES];

    logic [IDX_W-1:0] look_idx;
    logic [TAG_W-1:0] look_tag;
    logic             look_hit;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;

    // Lookup reads the registered table, so a same-cycle update is seen next cycle.
    assign look_idx   = pc[IDX_W-1:0];
    assign look_tag   = pc[ADDR_W-1:IDX_W];
    assign look_hit   = tbl_valid[look_idx] && (tbl_tag[look_idx] == look_tag);
    assign pc_4       = pc + ADDR_W'(1);
    assign pc_guessed = (look_hit && tbl_cnt[look_idx][1]) ? tbl_target[look_idx] : pc_4;
    assign bht_state  = look_hit ? tbl_cnt[look_idx] : 2'b00;

    assign upd_idx = upd_pc[IDX_W-1:0];
    assign upd_tag = upd_pc[ADDR_W-1:IDX_W];
    assign upd_hit = tbl_valid[upd_idx] && (tbl_tag[upd_idx] == upd_tag);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (redirect) begin
            pc <= redirect_pc;
        end else if (en) begin
            pc <= pc_guessed;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tbl_valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tbl_tag[i]    <= '0;
                tbl_target[i] <= '0;
                tbl_cnt[i]    <= 2'b00;
            end
        end else if (upd_valid) begin
            if (upd_hit) begin
                if (upd_taken) begin
                    if (tbl_cnt[upd_idx] != 2'b11) begin
                        tbl_cnt[upd_idx] <= tbl_cnt[upd_idx] + 2'b01;
                    end
                    tbl_target[upd_idx] <= upd_target;
                end else if (tbl_cnt[upd_idx] != 2'b00) begin
                    tbl_cnt[upd_idx] <= tbl_cnt[upd_idx] - 2'b01;
                end
            end else if (upd_taken) begin
                // Taken miss replaces whatever occupies the slot, starting weakly taken.
                tbl_valid[upd_idx]  <= 1'b1;
                tbl_tag[upd_idx]    <= upd_tag;
                tbl_target[upd_idx] <= upd_target;
                tbl_cnt[upd_idx]    <= 2'b10;
            end
        end
    end

`ifdef BHT_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_lookups <= 32'd0;
            stat_mispred <= 32'd0;
        end else begin
            if (en && !redirect) begin
                stat_lookups <= stat_lookups + 32'd1;
            end
            if (redirect) begin
                stat_mispred <= stat_mispred + 32'd1;
            end
        end
    end
`else
    assign stat_lookups = 32'd0;
    assign stat_mispred = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_predictor.sv
// Self-checking bench for fetch_predictor: directed walk-through plus randomized
// traffic compared against a table-of-entries reference model.
module tb_fetch_predictor;

    localparam int AW   = 10;
    localparam int NENT = 8;
    localparam int AMOD = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic          redirect = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          upd_valid = 1'b0;
    logic [AW-1:0] upd_pc = '0;
    logic          upd_taken = 1'b0;
    logic [AW-1:0] upd_target = '0;
    logic [AW-1:0] pc;
    logic [AW-1:0] pc_4;
    logic [AW-1:0] pc_guessed;
    logic [1:0]    bht_state;
    logic [31:0]   stat_lookups;
    logic [31:0]   stat_mispred;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: one record per BTB slot, plain integers.
    bit m_valid [NENT];
    int m_tag   [NENT];
    int m_tgt   [NENT];
    int m_cnt   [NENT];
    int m_pc;
    int m_look;
    int m_mis;

    fetch_predictor dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .upd_valid    (upd_valid),
        .upd_pc       (upd_pc),
        .upd_taken    (upd_taken),
        .upd_target   (upd_target),
        .pc           (pc),
        .pc_4         (pc_4),
        .pc_guessed   (pc_guessed),
        .bht_state    (bht_state),
        .stat_lookups (stat_lookups),
        .stat_mispred (stat_mispred)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit m_hit(input int a);
        return m_valid[a % NENT] && (m_tag[a % NENT] == a / NENT);
    endfunction

    function automatic int m_next_seq(input int a);
        return (a + 1) % AMOD;
    endfunction

    function automatic int m_guess(input int a);
        if (m_hit(a) && m_cnt[a % NENT] >= 2) return m_tgt[a % NENT];
        return m_next_seq(a);
    endfunction

    function automatic int m_state(input int a);
        return m_hit(a) ? m_cnt[a % NENT] : 0;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NENT; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 0;
            m_tgt[i]   = 0;
            m_cnt[i]   = 0;
        end
        m_pc   = 0;
        m_look = 0;
        m_mis  = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic m_advance();
        int nxt;
        int k;
        if (redirect) nxt = int'(redirect_pc);
        else if (en)  nxt = m_guess(m_pc);
        else          nxt = m_pc;
        if (en && !redirect) m_look++;
        if (redirect)        m_mis++;
        if (upd_valid) begin
            k = int'(upd_pc) % NENT;
            if (m_hit(int'(upd_pc))) begin
                if (upd_taken) begin
                    m_cnt[k] = (m_cnt[k] < 3) ? m_cnt[k] + 1 : 3;
                    m_tgt[k] = int'(upd_target);
                end else begin
                    m_cnt[k] = (m_cnt[k] > 0) ? m_cnt[k] - 1 : 0;
                end
            end else if (upd_taken) begin
                m_valid[k] = 1'b1;
                m_tag[k]   = int'(upd_pc) / NENT;
                m_tgt[k]   = int'(upd_target);
                m_cnt[k]   = 2;
            end
        end
        m_pc = nxt;
    endtask

    task automatic compare_all();
        chk("pc",         32'(pc),         32'(m_pc));
        chk("pc_4",       32'(pc_4),       32'(m_next_seq(m_pc)));
        chk("pc_guessed", 32'(pc_guessed), 32'(m_guess(m_pc)));
        chk("bht_state",  32'(bht_state),  32'(m_state(m_pc)));
`ifdef BHT_STATS_EN
        chk("stat_lookups", stat_lookups, 32'(m_look));
        chk("stat_mispred", stat_mispred, 32'(m_mis));
`else
        chk("stat_lookups", stat_lookups, 32'd0);
        chk("stat_mispred", stat_mispred, 32'd0);
`endif
    endtask

    task automatic step(input bit e, input bit r, input int rpc,
                        input bit uv, input int upc, input bit ut, input int utgt);
        en          = e;
        redirect    = r;
        redirect_pc = AW'(rpc);
        upd_valid   = uv;
        upd_pc      = AW'(upc);
        upd_taken   = ut;
        upd_target  = AW'(utgt);
        m_advance();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        en = 1'b0; redirect = 1'b0; upd_valid = 1'b0;
        rst = 1'b1;
        #1;
        m_reset();
        compare_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        compare_all();
    endtask

    function automatic int pick_addr();
        if ($urandom_range(0, 9) == 0) return int'($urandom_range(0, AMOD - 1));
        return int'($urandom_range(0, 31));
    endfunction

    initial begin
        @(negedge clk);
        do_reset();
        chk("rst_pc", 32'(pc), 32'h0);
        chk("rst_guess", 32'(pc_guessed), 32'h1);

        // Sequential fetch from reset.
        for (int i = 1; i < 4; i++) begin
            step(1, 0, 0, 0, 0, 0, 0);
            chk("seq_pc", 32'(pc), 32'(i));
            chk("seq_guess", 32'(pc_guessed), 32'(i + 1));
            chk("seq_state", 32'(bht_state), 32'd0);
        end

        // Allocate 0x005 -> 0x040 and fetch it.
        step(0, 0, 0, 1, 'h005, 1, 'h040);
        step(0, 1, 'h005, 0, 0, 0, 0);
        chk("alloc_state", 32'(bht_state), 32'd2);
        chk("alloc_guess", 32'(pc_guessed), 32'h040);
        step(1, 0, 0, 0, 0, 0, 0);
        chk("alloc_jump", 32'(pc), 32'h040);

        // Saturate up, then walk down.
        step(0, 1, 'h005, 1, 'h005, 1, 'h040);
        step(0, 0, 0, 1, 'h005, 1, 'h040);
        step(0, 0, 0, 1, 'h005, 1, 'h040);
        chk("sat_hi", 32'(bht_state), 32'd3);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 1, 'h005, 0, 0);
            chk("dec_state", 32'(bht_state), 32'((i < 2) ? 2 - i : 0));
            chk("dec_guess", 32'(pc_guessed), (i == 0) ? 32'h040 : 32'h006);
        end

        // Aliasing index: not-taken miss leaves the slot, taken miss replaces it.
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 'h00D, 0, 0);
        chk("alias_nt_pc5", 32'(bht_state), 32'd0);
        step(0, 1, 'h00D, 0, 0, 0, 0);
        chk("alias_nt_miss", 32'(pc_guessed), 32'h00E);
        step(0, 0, 0, 1, 'h00D, 1, 'h080);
        chk("alias_t_state", 32'(bht_state), 32'd2);
        chk("alias_t_guess", 32'(pc_guessed), 32'h080);
        step(0, 1, 'h005, 0, 0, 0, 0);
        chk("alias_old_miss", 32'(pc_guessed), 32'h006);

        // Redirect while stalled, then wrap.
        step(0, 1, 'h3FF, 0, 0, 0, 0);
        chk("wrap_pc", 32'(pc), 32'h3FF);
        chk("wrap_pc4", 32'(pc_4), 32'h000);
        chk("wrap_guess", 32'(pc_guessed), 32'h000);

        // Reset mid-run discards the table.
        step(0, 0, 0, 1, 'h005, 1, 'h040);
        do_reset();
        step(0, 1, 'h005, 0, 0, 0, 0);
        chk("post_rst_state", 32'(bht_state), 32'd0);
        chk("post_rst_guess", 32'(pc_guessed), 32'h006);

        // Randomized traffic with occasional reset.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, pick_addr(),
                     $urandom_range(0, 1) == 1, pick_addr(), $urandom_range(0, 2) != 0,
                     pick_addr());
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
